// File: rtl/exec_stage_mc_if.sv
// ---------------------------------------------------------------------------
// exec_stage_mc_if
// Signal bundle between the ID/EX register, the execute stage and the EX/MEM
// register consumers. Parameterised with the same WIDTH / RA_W as the stage.
//
// master modport : the pipeline side driving EX (ID/EX contents, flush,
//                  mem_stall) and observing its outputs.
// slave modport  : the execute stage itself.
//
// Inputs to EX  : valid_in, flush, mem_stall, op, a, b, imm, pc_next,
//                 alu_src, wr_reg, reg_write, mem_read, mem_write, mem_to_reg
// Outputs of EX : stall_out, take_branch, branch_target, err and the EX/MEM
//                 register valid_q, result_q, st_data_q, wr_reg_q,
//                 reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q
// ---------------------------------------------------------------------------
interface exec_stage_mc_if #(
   parameter int WIDTH = 16,
   parameter int RA_W  = 3
);
   // Instruction and control presented by ID/EX
   logic             valid_in;
   logic             flush;
   logic             mem_stall;
   logic [3:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] imm;
   logic [WIDTH-1:0] pc_next;
   logic             alu_src;
   logic [RA_W-1:0]  wr_reg;
   logic             reg_write;
   logic             mem_read;
   logic             mem_write;
   logic             mem_to_reg;

   // Combinational responses of the stage
   logic             stall_out;
   logic             take_branch;
   logic [WIDTH-1:0] branch_target;
   logic             err;

   // EX/MEM pipeline register
   logic             valid_q;
   logic [WIDTH-1:0] result_q;
   logic [WIDTH-1:0] st_data_q;
   logic [RA_W-1:0]  wr_reg_q;
   logic             reg_write_q;
   logic             mem_read_q;
   logic             mem_write_q;
   logic             mem_to_reg_q;

   modport master (
      output valid_in, flush, mem_stall, op, a, b, imm, pc_next, alu_src,
             wr_reg, reg_write, mem_read, mem_write, mem_to_reg,
      input  stall_out, take_branch, branch_target, err,
             valid_q, result_q, st_data_q, wr_reg_q,
             reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q
   );

   modport slave (
      input  valid_in, flush, mem_stall, op, a, b, imm, pc_next, alu_src,
             wr_reg, reg_write, mem_read, mem_write, mem_to_reg,
      output stall_out, take_branch, branch_target, err,
             valid_q, result_q, st_data_q, wr_reg_q,
             reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q
   );
endinterface

// File: rtl/exec_stage_mc.sv
// ---------------------------------------------------------------------------
// exec_stage_mc
// Execute stage of the pipelined core with its EX/MEM register. Runs the
// single-cycle ALU/compare ops, resolves branches and JALR, and (optionally)
// an iterative shift-add multiplier that stalls upstream while it works.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-low reset
//   bus  - exec_stage_mc_if.slave: ID/EX inputs, flush, mem_stall,
//          stall_out / take_branch / branch_target / err and the EX/MEM
//          register outputs (*_q)
//
// Build option:
//   EXEC_STAGE_MUL_EN - when defined, op 8 (MUL) runs on the multi-cycle
//                       multiplier FSM. When undefined there is no FSM or
//                       multiplier; op 8 is treated as an illegal op.
// ---------------------------------------------------------------------------
module exec_stage_mc #(
   parameter int WIDTH = 16,
   parameter int RA_W  = 3
) (
   input logic            clk,
   input logic            rst,
   exec_stage_mc_if.slave bus
);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_XOR  = 4'd3;
   localparam logic [3:0] OP_SLT  = 4'd4;
   localparam logic [3:0] OP_SEQ  = 4'd5;
   localparam logic [3:0] OP_SLE  = 4'd6;
   localparam logic [3:0] OP_LBI  = 4'd7;
   localparam logic [3:0] OP_MUL  = 4'd8;
   localparam logic [3:0] OP_BEQZ = 4'd9;
   localparam logic [3:0] OP_BNEZ = 4'd10;
   localparam logic [3:0] OP_BLTZ = 4'd11;
   localparam logic [3:0] OP_BGEZ = 4'd12;
   localparam logic [3:0] OP_JALR = 4'd13;

`ifdef EXEC_STAGE_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] alu_res;
   logic [WIDTH-1:0] br_tgt;
   logic             op_legal;
   logic             br_cond;
   logic             lt_s;
   logic             accept;
   logic             load_single;
   logic             is_idle;

   logic             valid_r;
   logic [WIDTH-1:0] result_r;
   logic [WIDTH-1:0] st_data_r;
   logic [RA_W-1:0]  wr_reg_r;
   logic             reg_write_r;
   logic             mem_read_r;
   logic             mem_write_r;
   logic             mem_to_reg_r;

`ifdef EXEC_STAGE_MUL_EN
   typedef enum logic {IDLE, BUSY} state_t;

   localparam int                CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplr;
   logic [WIDTH-1:0] prod;
   logic [WIDTH-1:0] prod_step;
   logic             start_mul;
   logic             last_step;
   logic             mul_done;

   logic [WIDTH-1:0] mul_st_data;
   logic [RA_W-1:0]  mul_wr_reg;
   logic             mul_reg_write;
   logic             mul_mem_read;
   logic             mul_mem_write;
   logic             mul_mem_to_reg;
`endif

   assign op_b = bus.alu_src ? bus.imm : bus.b;
   assign lt_s = $signed(bus.a) < $signed(op_b);

   // Decode the op into a single-cycle result, a branch condition and a
   // redirect target. JALR is the only op whose target is register-relative;
   // every conditional branch is PC-relative. Anything not listed is illegal.
   always_comb begin
      alu_res  = '0;
      br_cond  = 1'b0;
      op_legal = 1'b1;
      br_tgt   = bus.pc_next + bus.imm;
      case (bus.op)
         OP_ADD:  alu_res = bus.a + op_b;
         OP_SUB:  alu_res = bus.a - op_b;
         OP_AND:  alu_res = bus.a & op_b;
         OP_XOR:  alu_res = bus.a ^ op_b;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, lt_s};
         OP_SEQ:  alu_res = {{(WIDTH-1){1'b0}}, (bus.a == op_b)};
         OP_SLE:  alu_res = {{(WIDTH-1){1'b0}}, (lt_s | (bus.a == op_b))};
         OP_LBI:  alu_res = bus.imm;
         OP_MUL:  op_legal = MUL_EN;
         OP_BEQZ: br_cond = (bus.a == '0);
         OP_BNEZ: br_cond = (bus.a != '0);
         OP_BLTZ: br_cond = bus.a[WIDTH-1];
         OP_BGEZ: br_cond = ~bus.a[WIDTH-1];
         OP_JALR: begin
            br_cond = 1'b1;
            br_tgt  = bus.a + bus.imm;
            alu_res = bus.pc_next;
         end
         default: op_legal = 1'b0;
      endcase
   end

   assign accept      = bus.valid_in & ~bus.flush & ~bus.mem_stall & is_idle;
   assign load_single = accept & op_legal & (bus.op != OP_MUL);

   assign bus.take_branch   = accept & br_cond;
   assign bus.branch_target = br_tgt;
   assign bus.err           = accept & ~op_legal;

`ifdef EXEC_STAGE_MUL_EN
   assign is_idle   = (state == IDLE);
   assign start_mul = accept & (bus.op == OP_MUL);
   assign last_step = (cnt == CNT_LAST);
   assign mul_done  = (state == BUSY) & ~bus.flush & ~bus.mem_stall & last_step;
   assign prod_step = prod + (mplr[0] ? mcand : '0);

   // The MUL is held at the input from acceptance until the final step, so
   // the stall drops in the cycle the last partial product is added.
   assign bus.stall_out = bus.mem_stall | start_mul | ((state == BUSY) & ~last_step);

   // State register of the multiplier controller.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. A flush aborts a multiply even while the memory stage
   // is stalling; otherwise a mem_stall freezes the controller in place.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start_mul) begin
               state_next = BUSY;
            end
         end
         BUSY: begin
            if (bus.flush) begin
               state_next = IDLE;
            end else if (!bus.mem_stall && last_step) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Shift-add datapath: on start the operands and the MUL's writeback
   // control are latched, then each unstalled BUSY cycle adds the shifted
   // multiplicand when the current multiplier bit is set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt            <= '0;
         mcand          <= '0;
         mplr           <= '0;
         prod           <= '0;
         mul_st_data    <= '0;
         mul_wr_reg     <= '0;
         mul_reg_write  <= 1'b0;
         mul_mem_read   <= 1'b0;
         mul_mem_write  <= 1'b0;
         mul_mem_to_reg <= 1'b0;
      end else if (start_mul) begin
         cnt            <= '0;
         mcand          <= bus.a;
         mplr           <= op_b;
         prod           <= '0;
         mul_st_data    <= bus.b;
         mul_wr_reg     <= bus.wr_reg;
         mul_reg_write  <= bus.reg_write;
         mul_mem_read   <= bus.mem_read;
         mul_mem_write  <= bus.mem_write;
         mul_mem_to_reg <= bus.mem_to_reg;
      end else if ((state == BUSY) && !bus.flush && !bus.mem_stall) begin
         cnt   <= cnt + 1'b1;
         prod  <= prod_step;
         mcand <= {mcand[WIDTH-2:0], 1'b0};
         mplr  <= {1'b0, mplr[WIDTH-1:1]};
      end
   end
`else
   assign is_idle       = 1'b1;
   assign bus.stall_out = bus.mem_stall;
`endif

   // EX/MEM register. A memory stall freezes it outright; otherwise every
   // cycle that does not complete an instruction loads a cleared bubble.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_r      <= 1'b0;
         result_r     <= '0;
         st_data_r    <= '0;
         wr_reg_r     <= '0;
         reg_write_r  <= 1'b0;
         mem_read_r   <= 1'b0;
         mem_write_r  <= 1'b0;
         mem_to_reg_r <= 1'b0;
      end else if (!bus.mem_stall) begin
         valid_r      <= 1'b0;
         result_r     <= '0;
         st_data_r    <= '0;
         wr_reg_r     <= '0;
         reg_write_r  <= 1'b0;
         mem_read_r   <= 1'b0;
         mem_write_r  <= 1'b0;
         mem_to_reg_r <= 1'b0;
`ifdef EXEC_STAGE_MUL_EN
         if (mul_done) begin
            valid_r      <= 1'b1;
            result_r     <= prod_step;
            st_data_r    <= mul_st_data;
            wr_reg_r     <= mul_wr_reg;
            reg_write_r  <= mul_reg_write;
            mem_read_r   <= mul_mem_read;
            mem_write_r  <= mul_mem_write;
            mem_to_reg_r <= mul_mem_to_reg;
         end else
`endif
         if (load_single) begin
            valid_r      <= 1'b1;
            result_r     <= alu_res;
            st_data_r    <= bus.b;
            wr_reg_r     <= bus.wr_reg;
            reg_write_r  <= bus.reg_write;
            mem_read_r   <= bus.mem_read;
            mem_write_r  <= bus.mem_write;
            mem_to_reg_r <= bus.mem_to_reg;
         end
      end
   end

   assign bus.valid_q      = valid_r;
   assign bus.result_q     = result_r;
   assign bus.st_data_q    = st_data_r;
   assign bus.wr_reg_q     = wr_reg_r;
   assign bus.reg_write_q  = reg_write_r;
   assign bus.mem_read_q   = mem_read_r;
   assign bus.mem_write_q  = mem_write_r;
   assign bus.mem_to_reg_q = mem_to_reg_r;

endmodule

// File: tb/tb_exec_stage_mc.sv
// ---------------------------------------------------------------------------
// tb_exec_stage_mc
// Self-checking bench for exec_stage_mc (WIDTH=16, RA_W=3): a table of
// directed single-cycle vectors, hand-written multi-cycle sequences and a
// randomized phase checked against an arithmetic reference model.
// Follows EXEC_STAGE_MUL_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_exec_stage_mc;

   localparam int WIDTH = 16;
   localparam int RA_W  = 3;
`ifdef EXEC_STAGE_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic clk;
   logic rst;
   int   n_compared   = 0;
   int   n_mismatched = 0;

   exec_stage_mc_if #(.WIDTH(WIDTH), .RA_W(RA_W)) bus ();

   exec_stage_mc #(.WIDTH(WIDTH), .RA_W(RA_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] imm;
      logic [15:0] pc;
      logic        alu_src;
      logic [15:0] exp_res;
      logic        exp_valid;
      logic        exp_take;
      logic        exp_err;
      logic        chk_tgt;
      logic [15:0] exp_tgt;
   } vec_t;

   vec_t vecs[18];

   function automatic vec_t mkVec(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                  input logic [15:0] imm, input logic [15:0] pc, input logic alu_src,
                                  input logic [15:0] exp_res, input logic exp_valid, input logic exp_take,
                                  input logic exp_err, input logic chk_tgt, input logic [15:0] exp_tgt);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.imm = imm; v.pc = pc; v.alu_src = alu_src;
      v.exp_res = exp_res; v.exp_valid = exp_valid; v.exp_take = exp_take;
      v.exp_err = exp_err; v.chk_tgt = chk_tgt; v.exp_tgt = exp_tgt;
      return v;
   endfunction

   // Behavioural reference: plain signed/unsigned arithmetic on the operands.
   function automatic void refExec(input logic [3:0] op, input logic [15:0] a, input logic [15:0] bsel,
                                   input logic [15:0] imm, input logic [15:0] pcn,
                                   output logic [15:0] res, output bit legal, output bit taken,
                                   output logic [15:0] tgt, output bit is_ctl);
      int sa;
      int sb;
      sa = $signed(a);
      sb = $signed(bsel);
      res = 16'h0; legal = 1'b1; taken = 1'b0; is_ctl = 1'b0;
      tgt = pcn + imm;
      case (op)
         4'd0:  res = a + bsel;
         4'd1:  res = a - bsel;
         4'd2:  res = a & bsel;
         4'd3:  res = a ^ bsel;
         4'd4:  res = (sa < sb) ? 16'd1 : 16'd0;
         4'd5:  res = (a == bsel) ? 16'd1 : 16'd0;
         4'd6:  res = (sa <= sb) ? 16'd1 : 16'd0;
         4'd7:  res = imm;
         4'd8:  begin legal = MUL_EN; res = a * bsel; end
         4'd9:  begin is_ctl = 1'b1; taken = (sa == 0); end
         4'd10: begin is_ctl = 1'b1; taken = (sa != 0); end
         4'd11: begin is_ctl = 1'b1; taken = (sa < 0); end
         4'd12: begin is_ctl = 1'b1; taken = (sa >= 0); end
         4'd13: begin is_ctl = 1'b1; taken = 1'b1; tgt = a + imm; res = pcn; end
         default: legal = 1'b0;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] imm, input logic [15:0] pc, input logic alu_src,
                                input logic valid);
      bus.op         = op;
      bus.a          = a;
      bus.b          = b;
      bus.imm        = imm;
      bus.pc_next    = pc;
      bus.alu_src    = alu_src;
      bus.valid_in   = valid;
      bus.flush      = 1'b0;
      bus.mem_stall  = 1'b0;
      bus.wr_reg     = 3'd5;
      bus.reg_write  = 1'b1;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.mem_to_reg = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Global time limit so the run always reaches a summary line.
   initial begin
      #500000;
      n_mismatched++;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

   // Main test sequence.
   initial begin
      logic [3:0]  r_op;
      logic [15:0] r_a, r_b, r_imm, r_pc, r_bsel, m_res, m_tgt;
      logic        r_src, r_valid, r_flush, r_stall, r_rw, r_mr, r_mw, r_mtr;
      logic [2:0]  r_wr;
      bit          m_legal, m_taken, m_ctl, acc;
      logic [15:0] e_res, e_st;
      logic [2:0]  e_wr;
      logic [4:0]  e_ctl;
      int          stall_cnt, bad_cnt;

      vecs[0]  = mkVec(4'd0,  16'hFFFF, 16'h0002, 16'h0000, 16'h0000, 1'b0, 16'h0001, 1, 0, 0, 0, 16'h0);
      vecs[1]  = mkVec(4'd1,  16'h0003, 16'h0005, 16'h0000, 16'h0000, 1'b0, 16'hFFFE, 1, 0, 0, 0, 16'h0);
      vecs[2]  = mkVec(4'd2,  16'hF0F0, 16'h0FF0, 16'h0000, 16'h0000, 1'b0, 16'h00F0, 1, 0, 0, 0, 16'h0);
      vecs[3]  = mkVec(4'd3,  16'hF0F0, 16'h0FF0, 16'h0000, 16'h0000, 1'b0, 16'hFF00, 1, 0, 0, 0, 16'h0);
      vecs[4]  = mkVec(4'd4,  16'h8000, 16'h0001, 16'h0000, 16'h0000, 1'b0, 16'h0001, 1, 0, 0, 0, 16'h0);
      vecs[5]  = mkVec(4'd4,  16'h0001, 16'h8000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1, 0, 0, 0, 16'h0);
      vecs[6]  = mkVec(4'd5,  16'h1234, 16'h0000, 16'h1234, 16'h0000, 1'b1, 16'h0001, 1, 0, 0, 0, 16'h0);
      vecs[7]  = mkVec(4'd6,  16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 16'h0001, 1, 0, 0, 0, 16'h0);
      vecs[8]  = mkVec(4'd6,  16'h0002, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1, 0, 0, 0, 16'h0);
      vecs[9]  = mkVec(4'd7,  16'h0000, 16'h0000, 16'hABCD, 16'h0000, 1'b0, 16'hABCD, 1, 0, 0, 0, 16'h0);
      vecs[10] = mkVec(4'd0,  16'h0010, 16'h0003, 16'hFFFF, 16'h0000, 1'b1, 16'h000F, 1, 0, 0, 0, 16'h0);
      vecs[11] = mkVec(4'd11, 16'h8000, 16'h0000, 16'hFFFC, 16'h0010, 1'b0, 16'h0000, 1, 1, 0, 1, 16'h000C);
      vecs[12] = mkVec(4'd9,  16'h0001, 16'h0000, 16'h0004, 16'h0020, 1'b0, 16'h0000, 1, 0, 0, 1, 16'h0024);
      vecs[13] = mkVec(4'd12, 16'h0000, 16'h0000, 16'h0002, 16'h0002, 1'b0, 16'h0000, 1, 1, 0, 1, 16'h0004);
      vecs[14] = mkVec(4'd10, 16'h0005, 16'h0000, 16'h0010, 16'h0010, 1'b0, 16'h0000, 1, 1, 0, 1, 16'h0020);
      vecs[15] = mkVec(4'd13, 16'h0100, 16'h0000, 16'h0008, 16'h0042, 1'b0, 16'h0042, 1, 1, 0, 1, 16'h0108);
      vecs[16] = mkVec(4'd14, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 1'b0, 16'h0000, 0, 0, 1, 0, 16'h0);
      vecs[17] = mkVec(4'd15, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 1'b0, 16'h0000, 0, 0, 1, 0, 16'h0);

      // Reset state.
      rst = 1'b0;
      applyStimulus(4'd0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
      tick();
      tick();
      checkOutput("reset valid_q", bus.valid_q, 0);
      checkOutput("reset result_q", bus.result_q, 0);
      checkOutput("reset st_data_q", bus.st_data_q, 0);
      checkOutput("reset wr_reg_q", bus.wr_reg_q, 0);
      checkOutput("reset enables", {bus.reg_write_q, bus.mem_read_q, bus.mem_write_q, bus.mem_to_reg_q}, 0);
      checkOutput("reset stall_out", bus.stall_out, 0);
      rst = 1'b1;
      tick();

      // Directed single-cycle vectors.
      for (int i = 0; i < 18; i++) begin
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].pc, vecs[i].alu_src, 1'b1);
         #1;
         checkOutput($sformatf("vec%0d take_branch", i), bus.take_branch, vecs[i].exp_take);
         checkOutput($sformatf("vec%0d err", i), bus.err, vecs[i].exp_err);
         checkOutput($sformatf("vec%0d stall_out", i), bus.stall_out, 0);
         if (vecs[i].chk_tgt)
            checkOutput($sformatf("vec%0d branch_target", i), bus.branch_target, vecs[i].exp_tgt);
         tick();
         checkOutput($sformatf("vec%0d valid_q", i), bus.valid_q, vecs[i].exp_valid);
         checkOutput($sformatf("vec%0d reg_write_q", i), bus.reg_write_q, vecs[i].exp_valid);
         if (vecs[i].exp_valid) begin
            checkOutput($sformatf("vec%0d result_q", i), bus.result_q, vecs[i].exp_res);
            checkOutput($sformatf("vec%0d st_data_q", i), bus.st_data_q, vecs[i].b);
            checkOutput($sformatf("vec%0d wr_reg_q", i), bus.wr_reg_q, 5);
         end
      end

      // Asynchronous reset while EX/MEM holds a live result.
      applyStimulus(4'd0, 16'd5, 16'd6, 16'h0, 16'h0, 1'b0, 1'b1);
      tick();
      checkOutput("pre-reset result_q", bus.result_q, 16'd11);
      bus.valid_in = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      checkOutput("async reset valid_q", bus.valid_q, 0);
      checkOutput("async reset result_q", bus.result_q, 0);
      checkOutput("async reset reg_write_q", bus.reg_write_q, 0);
      tick();
      rst = 1'b1;
      tick();

`ifdef EXEC_STAGE_MUL_EN
      // MUL 300*7: 16 stall cycles, bubbles T1..T16, result at T17.
      applyStimulus(4'd8, 16'd300, 16'd7, 16'h0, 16'h0, 1'b0, 1'b1);
      #1;
      stall_cnt = 0;
      bad_cnt   = 0;
      for (int c = 0; c < 100; c++) begin
         if (!bus.stall_out) break;
         stall_cnt++;
         tick();
         if (bus.valid_q !== 1'b0) bad_cnt++;
      end
      checkOutput("mul stall cycles", stall_cnt, 16);
      checkOutput("mul bubble cycles with valid_q", bad_cnt, 0);
      tick();
      checkOutput("mul result_q", bus.result_q, 16'd2100);
      checkOutput("mul valid_q", bus.valid_q, 1);
      checkOutput("mul reg_write_q", bus.reg_write_q, 1);
      checkOutput("mul st_data_q", bus.st_data_q, 16'd7);
      checkOutput("mul wr_reg_q", bus.wr_reg_q, 5);
      bus.valid_in = 1'b0;
      tick();

      // Flush at T5 aborts the multiply; an ADD is accepted at T6.
      applyStimulus(4'd8, 16'd5, 16'd3, 16'h0, 16'h0, 1'b0, 1'b1);
      for (int c = 0; c < 5; c++) tick();
      bus.flush = 1'b1;
      tick();
      applyStimulus(4'd0, 16'd1, 16'd2, 16'h0, 16'h0, 1'b0, 1'b1);
      #1;
      checkOutput("flush T6 valid_q", bus.valid_q, 0);
      checkOutput("flush T6 stall_out", bus.stall_out, 0);
      tick();
      checkOutput("post-flush add result_q", bus.result_q, 16'd3);
      checkOutput("post-flush add valid_q", bus.valid_q, 1);
      bus.valid_in = 1'b0;
      tick();

      // mem_stall for T4..T6 pushes the result to T20.
      applyStimulus(4'd8, 16'd1234, 16'd56, 16'h0, 16'h0, 1'b0, 1'b1);
      for (int c = 0; c < 4; c++) tick();
      bad_cnt = 0;
      bus.mem_stall = 1'b1;
      for (int c = 4; c < 7; c++) begin
         #1;
         checkOutput($sformatf("mul mem_stall T%0d stall_out", c), bus.stall_out, 1);
         tick();
         if (bus.valid_q !== 1'b0) bad_cnt++;
      end
      bus.mem_stall = 1'b0;
      for (int c = 7; c < 20; c++) begin
         if (bus.valid_q !== 1'b0) bad_cnt++;
         tick();
      end
      checkOutput("stalled mul early valid_q", bad_cnt, 0);
      checkOutput("stalled mul result_q", bus.result_q, 16'h0DF0);
      checkOutput("stalled mul valid_q", bus.valid_q, 1);
      bus.valid_in = 1'b0;
      tick();

      // Reset mid-multiply drops it; the stage is idle afterwards.
      applyStimulus(4'd8, 16'd9, 16'd9, 16'h0, 16'h0, 1'b0, 1'b1);
      for (int c = 0; c < 3; c++) tick();
      bus.valid_in = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      checkOutput("mid-mul reset valid_q", bus.valid_q, 0);
      checkOutput("mid-mul reset result_q", bus.result_q, 0);
      checkOutput("mid-mul reset stall_out", bus.stall_out, 0);
      tick();
      rst = 1'b1;
      applyStimulus(4'd0, 16'd7, 16'd8, 16'h0, 16'h0, 1'b0, 1'b1);
      #1;
      checkOutput("post-reset add stall_out", bus.stall_out, 0);
      tick();
      checkOutput("post-reset add result_q", bus.result_q, 16'd15);
      bus.valid_in = 1'b0;
      tick();
`else
      // Without the multiplier, op 8 is an illegal op: error, bubble, no stall.
      applyStimulus(4'd8, 16'd300, 16'd7, 16'h0, 16'h0, 1'b0, 1'b1);
      #1;
      checkOutput("nomul err", bus.err, 1);
      checkOutput("nomul stall_out", bus.stall_out, 0);
      tick();
      checkOutput("nomul valid_q", bus.valid_q, 0);
      checkOutput("nomul reg_write_q", bus.reg_write_q, 0);
      bus.valid_in = 1'b0;
      tick();
`endif

      // Randomized single-cycle traffic with flush and mem_stall.
      applyStimulus(4'd0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
      tick();
      e_ctl = 5'b0; e_res = 16'h0; e_st = 16'h0; e_wr = 3'd0;
      for (int n = 0; n < 300; n++) begin
         r_op = 4'($urandom_range(15));
`ifdef EXEC_STAGE_MUL_EN
         if (r_op == 4'd8) r_op = 4'd0;
`endif
         r_a     = 16'($urandom);
         r_b     = 16'($urandom);
         r_imm   = 16'($urandom);
         r_pc    = 16'($urandom);
         r_src   = 1'($urandom_range(1));
         r_valid = ($urandom_range(3) != 0);
         r_flush = ($urandom_range(7) == 0);
         r_stall = ($urandom_range(5) == 0);
         r_wr    = 3'($urandom_range(7));
         r_rw    = 1'($urandom_range(1));
         r_mr    = 1'($urandom_range(1));
         r_mw    = 1'($urandom_range(1));
         r_mtr   = 1'($urandom_range(1));
         applyStimulus(r_op, r_a, r_b, r_imm, r_pc, r_src, r_valid);
         bus.flush = r_flush; bus.mem_stall = r_stall; bus.wr_reg = r_wr;
         bus.reg_write = r_rw; bus.mem_read = r_mr; bus.mem_write = r_mw; bus.mem_to_reg = r_mtr;
         #1;
         r_bsel = r_src ? r_imm : r_b;
         refExec(r_op, r_a, r_bsel, r_imm, r_pc, m_res, m_legal, m_taken, m_tgt, m_ctl);
         acc = r_valid && !r_flush && !r_stall;
         checkOutput("rnd take_branch", bus.take_branch, acc && m_taken);
         checkOutput("rnd err", bus.err, acc && !m_legal);
         checkOutput("rnd stall_out", bus.stall_out, r_stall);
         if (m_ctl) checkOutput("rnd branch_target", bus.branch_target, m_tgt);
         if (!r_stall) begin
            if (acc && m_legal) begin
               e_ctl = {1'b1, r_rw, r_mr, r_mw, r_mtr};
               e_res = m_res; e_st = r_b; e_wr = r_wr;
            end else begin
               e_ctl = 5'b0;
            end
         end
         tick();
         checkOutput("rnd valid/enables",
                     {bus.valid_q, bus.reg_write_q, bus.mem_read_q, bus.mem_write_q, bus.mem_to_reg_q}, e_ctl);
         if (e_ctl[4]) begin
            checkOutput("rnd result_q", bus.result_q, e_res);
            checkOutput("rnd st_data_q", bus.st_data_q, e_st);
            checkOutput("rnd wr_reg_q", bus.wr_reg_q, e_wr);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
